// File: rtl/resilient_delay_tuner_if.sv
// Interface between the delay tuner and its surroundings.
// It carries the tuner inputs (enable and the error pulses), the four-phase
// handshake to the delay line, and the status outputs.
//   slave  : the tuner side. Inputs are enable, err0_evt, err1_evt and cfg_ack.
//            Outputs are cfg_req, dly_code, score, busy and sat_hi.
//   master : the environment side, with every direction reversed.
// DLY_W and SCORE_W must match the parameters of the tuner this is bound to.
interface resilient_delay_tuner_if #(
  parameter int DLY_W   = 4,
  parameter int SCORE_W = 8
);
  logic               enable;
  logic               err0_evt;
  logic               err1_evt;
  logic               cfg_ack;
  logic               cfg_req;
  logic [DLY_W-1:0]   dly_code;
  logic [SCORE_W-1:0] score;
  logic               busy;
  logic               sat_hi;

  modport master (
    output enable, err0_evt, err1_evt, cfg_ack,
    input  cfg_req, dly_code, score, busy, sat_hi
  );

  modport slave (
    input  enable, err0_evt, err1_evt, cfg_ack,
    output cfg_req, dly_code, score, busy, sat_hi
  );
endinterface

// File: rtl/resilient_delay_tuner.sv
// Supervisor that retunes the matched delay of a bundled-data pipeline stage.
// Each measurement window it counts error events: Err0 is worth 1 and Err1 is
// worth 2. The score saturates rather than wrapping. After the window the tuner
// moves the delay code by one step. Every new code is handed to the delay line
// over a four-phase req/ack handshake.
// Ports:
//   clk  rising-edge system clock
//   rst  asynchronous active-high reset
//   bus  slave modport:
//        inputs  enable, err0_evt, err1_evt, cfg_ack
//        outputs cfg_req, dly_code, score, busy, sat_hi
// SCORE_W must be at least 2.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | tuner stopped; score, window counter and err1_seen held clear
// S_MEASURE | accumulating error score over WIN_CYCLES cycles
// S_DECIDE  | compare score to thresholds; waits here while cfg_ack is stuck
// S_REQ_HI  | new code offered, cfg_req=1, waiting for cfg_ack=1
// S_REQ_LO  | cfg_req dropped, waiting for cfg_ack=0
module resilient_delay_tuner #(
  parameter int DLY_W      = 4,
  parameter int DLY_INIT   = 8,
  parameter int DLY_MIN    = 2,
  parameter int DLY_MAX    = 15,
  parameter int WIN_CYCLES = 256,
  parameter int SCORE_W    = 8,
  parameter int HI_THRESH  = 4,
  parameter int LO_THRESH  = 0
) (
  input logic                    clk,
  input logic                    rst,
  resilient_delay_tuner_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MEASURE,
    S_DECIDE,
    S_REQ_HI,
    S_REQ_LO
  } state_t;

  localparam int CNT_W = $clog2(WIN_CYCLES);
  localparam logic [CNT_W-1:0]   WIN_LAST = CNT_W'(WIN_CYCLES - 1);
  localparam logic [DLY_W-1:0]   CODE_INIT = DLY_W'(DLY_INIT);
  localparam logic [DLY_W-1:0]   CODE_MIN  = DLY_W'(DLY_MIN);
  localparam logic [DLY_W-1:0]   CODE_MAX  = DLY_W'(DLY_MAX);
  localparam logic [SCORE_W-1:0] HI_T      = SCORE_W'(HI_THRESH);
  localparam logic [SCORE_W-1:0] LO_T      = SCORE_W'(LO_THRESH);

  state_t             state, state_nxt;
  logic [DLY_W-1:0]   dly_q, dly_new;
  logic [SCORE_W-1:0] score_q, score_sat;
  logic [SCORE_W:0]   score_sum;
  logic [CNT_W-1:0]   win_cnt;
  logic               err1_seen;
  logic               req_q;
  logic               inc_ok, dec_ok, change;

  // The increment is err0 + 2*err1, which is just {err1, err0}.
  // The sum is one bit wider than the score so that overflow can be detected.
  always_comb begin
    score_sum = {1'b0, score_q} + {{(SCORE_W-1){1'b0}}, bus.err1_evt, bus.err0_evt};
    score_sat = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
  end

  // While the FSM sits in DECIDE, score, err1_seen and dly_q are all frozen.
  // The decision therefore stays the same until the FSM leaves DECIDE.
  always_comb begin
    inc_ok  = (score_q >= HI_T) && (dly_q < CODE_MAX);
    dec_ok  = !inc_ok && (score_q <= LO_T) && !err1_seen && (dly_q > CODE_MIN);
    change  = inc_ok || dec_ok;
    dly_new = inc_ok ? dly_q + DLY_W'(1) : dly_q - DLY_W'(1);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (bus.enable) state_nxt = S_MEASURE;
      end
      S_MEASURE: begin
        if (!bus.enable)            state_nxt = S_IDLE;
        else if (win_cnt == WIN_LAST) state_nxt = S_DECIDE;
      end
      S_DECIDE: begin
        // A stale ack from the previous transfer holds back the new request.
        if (change) begin
          if (!bus.cfg_ack) state_nxt = S_REQ_HI;
        end else begin
          state_nxt = bus.enable ? S_MEASURE : S_IDLE;
        end
      end
      S_REQ_HI: begin
        if (bus.cfg_ack) state_nxt = S_REQ_LO;
      end
      S_REQ_LO: begin
        if (!bus.cfg_ack) state_nxt = bus.enable ? S_MEASURE : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath registers: score, window counter, delay code and request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dly_q     <= CODE_INIT;
      req_q     <= 1'b0;
      score_q   <= '0;
      win_cnt   <= '0;
      err1_seen <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          score_q   <= '0;
          win_cnt   <= '0;
          err1_seen <= 1'b0;
        end
        S_MEASURE: begin
          score_q   <= score_sat;
          err1_seen <= err1_seen | bus.err1_evt;
          win_cnt   <= (win_cnt == WIN_LAST) ? '0 : win_cnt + CNT_W'(1);
        end
        S_DECIDE: begin
          if (state_nxt != S_DECIDE) begin
            score_q   <= '0;
            win_cnt   <= '0;
            err1_seen <= 1'b0;
            if (change) begin
              dly_q <= dly_new;
              req_q <= 1'b1;
            end
          end
        end
        S_REQ_HI: begin
          if (bus.cfg_ack) req_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    bus.cfg_req  = req_q;
    bus.dly_code = dly_q;
    bus.score    = score_q;
    bus.busy     = (state != S_IDLE);
    bus.sat_hi   = (dly_q == CODE_MAX);
  end

endmodule

// File: tb/tb_resilient_delay_tuner.sv
// Self-checking bench for resilient_delay_tuner.
// The main DUT uses a 16-cycle window. It is driven from a table of windows,
// and each window's expected outcome goes through a scoreboard queue.
// Hand-written sequences then cover the multi-cycle corner cases:
// a stale ack, enable dropped mid-handshake, and reset mid-handshake.
// A second DUT with a 128-cycle window covers score saturation.
module tb_resilient_delay_tuner;
  localparam int WIN = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  resilient_delay_tuner_if #(.DLY_W(4), .SCORE_W(8)) bus ();
  resilient_delay_tuner_if #(.DLY_W(4), .SCORE_W(8)) sbus ();

  resilient_delay_tuner #(
    .DLY_W(4), .DLY_INIT(8), .DLY_MIN(2), .DLY_MAX(15), .WIN_CYCLES(WIN),
    .SCORE_W(8), .HI_THRESH(4), .LO_THRESH(0)
  ) u_dut (.clk(clk), .rst(rst), .bus(bus));

  resilient_delay_tuner #(
    .DLY_W(4), .DLY_INIT(8), .DLY_MIN(2), .DLY_MAX(15), .WIN_CYCLES(128),
    .SCORE_W(8), .HI_THRESH(4), .LO_THRESH(0)
  ) u_sat (.clk(clk), .rst(rst), .bus(sbus));

  typedef struct {
    int         n0;
    int         n1;
    int         nb;
    int         ack_dly;
    logic [3:0] exp_code;
    bit         exp_hs;
    bit         exp_sat;
  } vec_t;

  typedef struct {
    logic [3:0] code;
    bit         hs;
    bit         sat;
  } exp_t;

  localparam int NV = 28;
  vec_t vecs[NV];
  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Starts at the negedge just after the DUT has entered MEASURE.
  // Ends at the negedge while the DUT is in DECIDE.
  task automatic drive_window(input int n0, input int n1, input int nb, input bit hold_ack);
    for (int i = 0; i < WIN; i++) begin
      bus.err1_evt = (i < nb + n1);
      bus.err0_evt = (i < nb) || ((i >= nb + n1) && (i < nb + n1 + n0));
      if (hold_ack && i >= 12) bus.cfg_ack = 1'b1;
      @(negedge clk);
    end
    bus.err0_evt = 1'b0;
    bus.err1_evt = 1'b0;
  endtask

  // Called with cfg_req=1 already observed. Raises ack after ack_dly cycles,
  // lowers it once req falls, and returns one negedge after ack goes low.
  task automatic complete_hs(input int ack_dly, input logic [3:0] code);
    int n;
    for (int d = 0; d < ack_dly; d++) begin
      chk("hs_req_held", bus.cfg_req, 1);
      chk("hs_code_stable", bus.dly_code, code);
      @(negedge clk);
    end
    bus.cfg_ack = 1'b1;
    @(negedge clk);
    n = 0;
    while (bus.cfg_req && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("hs_req_fall", bus.cfg_req, 0);
    chk("hs_code_after", bus.dly_code, code);
    bus.cfg_ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   exp_score;

    vecs[0]  = '{0, 0, 0,  3, 4'd7,  1, 0};
    vecs[1]  = '{0, 2, 0,  2, 4'd8,  1, 0};
    vecs[2]  = '{0, 2, 0,  3, 4'd9,  1, 0};
    vecs[3]  = '{0, 1, 0,  1, 4'd9,  0, 0};
    vecs[4]  = '{4, 0, 0,  1, 4'd10, 1, 0};
    vecs[5]  = '{3, 0, 0,  1, 4'd10, 0, 0};
    vecs[6]  = '{0, 0, 0,  2, 4'd9,  1, 0};
    vecs[7]  = '{0, 0, 4,  1, 4'd10, 1, 0};
    vecs[8]  = '{0, 5, 0,  1, 4'd11, 1, 0};
    vecs[9]  = '{0, 0, 16, 1, 4'd12, 1, 0};
    vecs[10] = '{16, 0, 0, 1, 4'd13, 1, 0};
    vecs[11] = '{0, 5, 0,  1, 4'd14, 1, 0};
    vecs[12] = '{0, 5, 0,  1, 4'd15, 1, 1};
    vecs[13] = '{0, 5, 0,  1, 4'd15, 0, 1};
    for (int k = 0; k < 13; k++)
      vecs[14+k] = '{0, 0, 0, 1, 4'(14 - k), 1, 0};
    vecs[27] = '{0, 0, 0,  1, 4'd2,  0, 0};

    bus.enable = 0; bus.err0_evt = 0; bus.err1_evt = 0; bus.cfg_ack = 0;
    sbus.enable = 0; sbus.err0_evt = 0; sbus.err1_evt = 0; sbus.cfg_ack = 0;

    repeat (2) @(negedge clk);
    chk("rst_code", bus.dly_code, 8);
    chk("rst_req", bus.cfg_req, 0);
    chk("rst_score", bus.score, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_sat", bus.sat_hi, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", bus.busy, 0);
    bus.enable = 1'b1;
    @(negedge clk);
    chk("measure_busy", bus.busy, 1);

    for (int k = 0; k < NV; k++) begin
      drive_window(vecs[k].n0, vecs[k].n1, vecs[k].nb, 1'b0);
      sb_q.push_back(exp_t'{vecs[k].exp_code, vecs[k].exp_hs, vecs[k].exp_sat});
      exp_score = vecs[k].n0 + 2 * vecs[k].n1 + 3 * vecs[k].nb;
      if (exp_score > 255) exp_score = 255;
      chk("win_score", bus.score, exp_score);
      @(negedge clk);
      e = sb_q.pop_front();
      chk("decide_req", bus.cfg_req, e.hs);
      chk("decide_code", bus.dly_code, e.code);
      chk("decide_sat", bus.sat_hi, e.sat);
      if (e.hs) begin
        complete_hs(vecs[k].ack_dly, e.code);
        chk("post_hs_busy", bus.busy, 1);
      end
      chk("new_win_score", bus.score, 0);
    end

    // Stale ack held into DECIDE: the request must wait until ack falls.
    drive_window(0, 2, 0, 1'b1);
    chk("stale_score", bus.score, 4);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("stale_no_req", bus.cfg_req, 0);
      chk("stale_code", bus.dly_code, 2);
      chk("stale_busy", bus.busy, 1);
    end
    bus.cfg_ack = 1'b0;
    @(negedge clk);
    chk("stale_req_rise", bus.cfg_req, 1);
    chk("stale_new_code", bus.dly_code, 3);
    complete_hs(1, 4'd3);

    // enable dropped during REQ_HI: handshake completes, then IDLE.
    drive_window(0, 0, 0, 1'b0);
    @(negedge clk);
    chk("endrop_req", bus.cfg_req, 1);
    chk("endrop_code", bus.dly_code, 2);
    bus.enable = 1'b0;
    complete_hs(10, 4'd2);
    chk("endrop_idle", bus.busy, 0);
    chk("endrop_code_kept", bus.dly_code, 2);

    // Reset asserted mid-REQ_HI, checked before any clock edge.
    bus.enable = 1'b1;
    @(negedge clk);
    drive_window(0, 2, 0, 1'b0);
    @(negedge clk);
    chk("rstmid_req_pre", bus.cfg_req, 1);
    chk("rstmid_code_pre", bus.dly_code, 3);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_req", bus.cfg_req, 0);
    chk("rstmid_code", bus.dly_code, 8);
    chk("rstmid_busy", bus.busy, 0);
    @(negedge clk);
    bus.enable = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // Score saturation: 100 back-to-back double events in a 128-cycle window.
    sbus.enable = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 128; i++) begin
      sbus.err0_evt = (i < 100);
      sbus.err1_evt = (i < 100);
      @(negedge clk);
      if (i == 83) chk("sat_score_252", sbus.score, 252);
      if (i == 84) chk("sat_score_255", sbus.score, 255);
      if (i == 85) chk("sat_no_wrap", sbus.score, 255);
    end
    chk("sat_decide_score", sbus.score, 255);
    @(negedge clk);
    chk("sat_req", sbus.cfg_req, 1);
    chk("sat_code_plus1", sbus.dly_code, 9);
    sbus.cfg_ack = 1'b1;
    @(negedge clk);
    chk("sat_req_fall", sbus.cfg_req, 0);
    sbus.cfg_ack = 1'b0;
    sbus.enable = 1'b0;
    @(negedge clk);
    chk("sat_idle", sbus.busy, 0);
    chk("sat_code_final", sbus.dly_code, 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
